regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the WB stage always wins; long-latency results wait in a
// 2-entry in-order FIFO, with a stall request once the head has aged. Define RF_ARB_STATS_EN for counters.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic [31:0] pend_mask,
  output logic        protocol_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] lu_wr_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [3:0] MAX_AGE = 4'(MAX_WAIT);

  function automatic logic [31:0] dec5(input logic [4:0] a);
    dec5 = 32'd1 << a;
  endfunction

  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  age_q, age_d;
  logic [1:0]  state_q, state_d;
  logic        perr_q, perr_d;
  logic [31:0] pend_q, pend_d;
  logic [4:0]  e0_addr_q, e0_addr_d, e1_addr_q, e1_addr_d;
  logic [31:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic        accept, enq, pop;
  logic [1:0]  level;

  // Handshake and write-port selection; rf passes the pipe through whenever the FIFO is empty.
  always_comb begin
    lu_ready = rst_n && (cnt_q != 2'd2);
    accept   = lu_valid && lu_ready;
    enq      = accept && (lu_waddr != 5'd0);
    pop      = !pipe_we && (cnt_q != 2'd0);
    rf_we    = pipe_we || (cnt_q != 2'd0);
    if (pipe_we || (cnt_q == 2'd0)) begin
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else begin
      rf_waddr = e0_addr_q;
      rf_wdata = e0_data_q;
    end
  end

  // FIFO next state: pop shifts entry 1 forward, enqueue lands behind whatever remains.
  always_comb begin
    e0_addr_d = e0_addr_q;
    e0_data_d = e0_data_q;
    e1_addr_d = e1_addr_q;
    e1_data_d = e1_data_q;
    level     = cnt_q - {1'b0, pop};
    if (pop) begin
      e0_addr_d = e1_addr_q;
      e0_data_d = e1_data_q;
    end
    if (enq) begin
      if (level == 2'd0) begin
        e0_addr_d = lu_waddr;
        e0_data_d = lu_wdata;
      end else begin
        e1_addr_d = lu_waddr;
        e1_data_d = lu_wdata;
      end
    end
    cnt_d = level + {1'b0, enq};
  end

  // Head age, FSM, sticky error and pending mask.
  always_comb begin
    age_d = age_q;
    if (pop || (cnt_q == 2'd0)) begin
      age_d = 4'd0;
    end else if (age_q != MAX_AGE) begin
      age_d = age_q + 4'd1;
    end

    state_d = PEND;
    if (cnt_d == 2'd0) begin
      state_d = IDLE;
    end else if (age_d == MAX_AGE) begin
      state_d = STALL;
    end

    perr_d = perr_q || (pipe_we && (state_q == STALL));

    pend_d = 32'd0;
    if (cnt_d != 2'd0) begin
      pend_d = pend_d | dec5(e0_addr_d);
    end
    if (cnt_d == 2'd2) begin
      pend_d = pend_d | dec5(e1_addr_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      age_q   <= 4'd0;
      state_q <= IDLE;
      perr_q  <= 1'b0;
      pend_q  <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      age_q   <= age_d;
      state_q <= state_d;
      perr_q  <= perr_d;
      pend_q  <= pend_d;
    end
  end

  // Payload needs no reset: the count register qualifies every use of it.
  always_ff @(posedge clk) begin
    e0_addr_q <= e0_addr_d;
    e0_data_q <= e0_data_d;
    e1_addr_q <= e1_addr_d;
    e1_data_q <= e1_data_d;
  end

  assign stall_req    = (state_q == STALL);
  assign pend_mask    = pend_q;
  assign protocol_err = perr_q;

`ifdef RF_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] lu_wr_cnt_q, lu_wr_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    lu_wr_cnt_d = lu_wr_cnt_q;
    if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (pop && (lu_wr_cnt_q != 16'hFFFF)) begin
      lu_wr_cnt_d = lu_wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      lu_wr_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lu_wr_cnt_q <= lu_wr_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign lu_wr_cnt = lu_wr_cnt_q;
`else
  assign stall_cnt = 16'd0;
  assign lu_wr_cnt = 16'd0;
`endif

endmodule
